int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Parametrised interrupt controller for the 6502 core; successor to the fixed 3-input sequencer.
- Synchronises asynchronous reset/NMI/IRQ pins and edge-detects NMI.
- Merges NUM_IRQ maskable IRQ sources and commits one request at each instruction boundary (sync).
- Supplies the CPU with a held, prioritised request and its vector address until the CPU acknowledges it.

Parameters:
NUM_IRQ, 4, number of active-low IRQ source lines (1..16)
SYNC_STAGES, 2, flip-flops per pin synchroniser (>=2)
NMI_EDGE, 1, 1 = NMI latched on falling edge (6502 behaviour); 0 = NMI level-sensitive

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  synchronous active-high system reset
ext_rst_n  in  1  asynchronous active-low reset pin
nmi_n  in  1  asynchronous active-low NMI pin
irq_n  in  NUM_IRQ  asynchronous active-low IRQ sources
irq_en  in  NUM_IRQ  per-source enable; 1 = source may raise IRQ
sync  in  1  CPU opcode-fetch cycle (instruction boundary)
i_flag  in  1  CPU interrupt-disable flag
int_ack  in  1  one-cycle pulse: CPU fetching vector low byte of current request
rst_req  out  1  reset request
nmi_req  out  1  committed NMI request
irq_req  out  1  committed IRQ request
vec  out  16  vector address of current request
irq_src  out  NUM_IRQ  synchronised, enabled, active IRQ sources (status)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values:
  - Synchronisers all 1 (inactive).
  - rst_latch=1, so rst_req=1 and vec=16'hFFFC.
  - nmi_pend=0, sel=NONE, nmi_req=0, irq_req=0.
  - irq_src=0.
- Synchronisers:
  - ext_rst_n, nmi_n and each irq_n bit pass through SYNC_STAGES flops.
  - Sampled values (s_*) lag the pins by SYNC_STAGES cycles.
- Reset latch:
  - Set while rst=1 or s_ext_rst_n=0.
  - Cleared on int_ack only when s_ext_rst_n=1 and rst=0.
  - rst_req = rst_latch, not gated by sync.
  - Reset pin low for a single synchronised cycle still yields a full reset sequence.
- NMI pending, NMI_EDGE=1:
  - nmi_pend sets one cycle after s_nmi_n goes 1->0.
  - Clears on int_ack when the committed request is NMI.
  - A new falling edge in the same cycle as a clearing ack wins: pend stays 1.
  - Holding nmi_n low yields exactly one NMI.
- NMI pending, NMI_EDGE=0: nmi_pend = ~s_nmi_n, and the ack does not clear it.
- IRQ:
  - irq_src = ~s_irq_n & irq_en.
  - irq_any = |irq_src & ~i_flag.
  - Level-sensitive; the ack does not clear the source.
- Commit register sel (NONE, IRQ, NMI, RST):
  - Loaded only when sync=1 and no request is outstanding (sel=NONE).
  - Priority: rst_latch -> RST, else nmi_pend -> NMI, else irq_any -> IRQ, else NONE.
  - Once committed, sel holds regardless of pin, i_flag or irq_en changes until int_ack; then sel=NONE.
- NMI hijack:
  - Applies when sel=IRQ and nmi_pend=1 on or before the int_ack cycle.
  - vec=16'hFFFA and nmi_req=1, irq_req=0.
  - The ack clears nmi_pend, matching the 6502 BRK/IRQ hijack.
- RST preemption: rst_latch setting while sel=NMI/IRQ overrides: sel forced to RST next cycle.
- Outputs:
  - nmi_req = (sel==NMI) or hijack; irq_req = (sel==IRQ) and not hijack.
  - Request outputs are mutually exclusive.
  - vec: RST 16'hFFFC, NMI/hijack 16'hFFFA, IRQ or NONE 16'hFFFE.
- Latency: pin edge to nmi_pend is SYNC_STAGES+1 cycles; nmi_pend to nmi_req is the next sync +1 cycle.
- int_ack with sel=NONE is ignored.
- rst mid-sequence discards sel and nmi_pend.

Decomposition:
- int_pkg:
  - sel enum (SEL_NONE, SEL_IRQ, SEL_NMI, SEL_RST).
  - Vector constants VEC_RST=16'hFFFC, VEC_NMI=16'hFFFA, VEC_IRQ=16'hFFFE.
- Sub-module sync_chain:
  - Parameters WIDTH and STAGES, reset value all-1.
  - Instantiated for the reset pin, the NMI pin and the irq_n bus.

Test Plan:
- rst=1 for 3 cycles then 0, sync pulse, then int_ack -> rst_req=1 and vec=FFFC until the ack cycle; rst_req=0 the cycle after.
- nmi_n 1->0 held 50 cycles, sync every 4 cycles, ack each request -> exactly one nmi_req, vec=FFFA; no second request while the pin stays low.
- irq_n=4'b1101, irq_en=4'b0010, i_flag=0 -> irq_src=4'b0010, irq_req after the next sync, vec=FFFE; repeat with i_flag=1 -> no request, irq_src still 4'b0010.
- IRQ committed, nmi_n falls 2 cycles before int_ack -> vec switches to FFFA, nmi_req=1, irq_req=0; after the ack nmi_pend=0, IRQ recommitted at the next sync.
- NMI and IRQ active in the same sync cycle -> NMI committed first; IRQ committed at the following sync after the ack.
- ext_rst_n pulsed low for 1 cycle while sel=IRQ -> rst_req=1 within SYNC_STAGES+1 cycles, vec=FFFC, irq_req=0; NMI_EDGE=0 build: nmi_n held low -> nmi_req again at every sync after each ack.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and vector addresses for the 6502 interrupt controller.
package int_pkg;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_IRQ  = 2'd1,
      SEL_NMI  = 2'd2,
      SEL_RST  = 2'd3
   } sel_t;

   localparam logic [15:0] VEC_RST = 16'hFFFC;
   localparam logic [15:0] VEC_NMI = 16'hFFFA;
   localparam logic [15:0] VEC_IRQ = 16'hFFFE;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop pin synchroniser; reset loads all-ones so active-low pins read inactive.
module sync_chain #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) stage[i] <= '1;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller for the 6502 core: synchronises pins, commits one request per
// instruction boundary and holds it with its vector until the CPU acknowledges.
module int_ctrl
   import int_pkg::*;
#(
   parameter int NUM_IRQ     = 4,
   parameter int SYNC_STAGES = 2,
   parameter bit NMI_EDGE    = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ext_rst_n,
   input  logic               nmi_n,
   input  logic [NUM_IRQ-1:0] irq_n,
   input  logic [NUM_IRQ-1:0] irq_en,
   input  logic               sync,
   input  logic               i_flag,
   input  logic               int_ack,
   output logic               rst_req,
   output logic               nmi_req,
   output logic               irq_req,
   output logic [15:0]        vec,
   output logic [NUM_IRQ-1:0] irq_src
);

   logic               s_ext_rst_n;
   logic               s_nmi_n;
   logic [NUM_IRQ-1:0] s_irq_n;
   logic               rst_latch;
   logic               nmi_pend;
   logic               hijack;
   logic               nmi_eff;
   logic               irq_any;
   sel_t               sel;
   sel_t               sel_nxt;

   sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_rst (
      .clk(clk), .rst(rst), .d(ext_rst_n), .q(s_ext_rst_n)
   );

   sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_nmi (
      .clk(clk), .rst(rst), .d(nmi_n), .q(s_nmi_n)
   );

   sync_chain #(.WIDTH(NUM_IRQ), .STAGES(SYNC_STAGES)) u_sync_irq (
      .clk(clk), .rst(rst), .d(irq_n), .q(s_irq_n)
   );

   // Reset request survives until the CPU fetches the reset vector with the pin released.
   always_ff @(posedge clk) begin
      if (rst || !s_ext_rst_n) begin
         rst_latch <= 1'b1;
      end else if (int_ack && sel == SEL_RST) begin
         rst_latch <= 1'b0;
      end
   end

   // An IRQ still waiting for its ack is serviced as NMI once an NMI is pending.
   assign hijack  = (sel == SEL_IRQ) && nmi_pend;
   assign nmi_eff = (sel == SEL_NMI) || hijack;

   if (NMI_EDGE) begin : g_nmi_edge
      logic s_nmi_prev;

      // A fresh falling edge beats a simultaneous clearing ack.
      always_ff @(posedge clk) begin
         if (rst) begin
            s_nmi_prev <= 1'b1;
            nmi_pend   <= 1'b0;
         end else begin
            s_nmi_prev <= s_nmi_n;
            if (s_nmi_prev && !s_nmi_n) begin
               nmi_pend <= 1'b1;
            end else if (int_ack && nmi_eff) begin
               nmi_pend <= 1'b0;
            end
         end
      end
   end else begin : g_nmi_level
      assign nmi_pend = ~s_nmi_n;
   end

   assign irq_src = ~s_irq_n & irq_en;
   assign irq_any = (|irq_src) & ~i_flag;

   always_comb begin
      sel_nxt = sel;
      if (sel == SEL_NONE) begin
         if (sync) begin
            if (rst_latch)     sel_nxt = SEL_RST;
            else if (nmi_pend) sel_nxt = SEL_NMI;
            else if (irq_any)  sel_nxt = SEL_IRQ;
         end
      end else if (rst_latch && sel != SEL_RST) begin
         sel_nxt = SEL_RST;
      end else if (int_ack) begin
         sel_nxt = SEL_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) sel <= SEL_NONE;
      else     sel <= sel_nxt;
   end

   // Reset dominates in the cycle before a preempted selection turns into SEL_RST.
   assign rst_req = rst_latch;
   assign nmi_req = nmi_eff & ~rst_latch;
   assign irq_req = (sel == SEL_IRQ) & ~hijack & ~rst_latch;
   assign vec     = rst_latch ? VEC_RST : (nmi_eff ? VEC_NMI : VEC_IRQ);

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: an edge-NMI build and a level-NMI build side by side.
module tb_int_ctrl;

   localparam int N = 4;

   typedef struct packed {
      logic         r;
      logic         n;
      logic         i;
      logic [15:0]  v;
      logic [N-1:0] s;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_v   [2];
   logic         sync_v  [2];
   logic         ack_v   [2];
   logic         probe_v [2];
   logic         nmi_v   [2];
   logic         ext_rst_n;
   logic [N-1:0] irq_n;
   logic [N-1:0] irq_en;
   logic         i_flag;

   logic         rr0, nr0, ir0, rr1, nr1, ir1;
   logic [15:0]  vv0, vv1;
   logic [N-1:0] ss0, ss1;

   obs_t  q0 [$];
   obs_t  q1 [$];
   string n0 [$];
   string n1 [$];
   int    n_chk  = 0;
   int    n_pass = 0;

   int_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(2), .NMI_EDGE(1'b1)) u_edge (
      .clk(clk), .rst(rst_v[0]), .ext_rst_n(ext_rst_n), .nmi_n(nmi_v[0]),
      .irq_n(irq_n), .irq_en(irq_en), .sync(sync_v[0]), .i_flag(i_flag),
      .int_ack(ack_v[0]), .rst_req(rr0), .nmi_req(nr0), .irq_req(ir0),
      .vec(vv0), .irq_src(ss0)
   );

   int_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(2), .NMI_EDGE(1'b0)) u_level (
      .clk(clk), .rst(rst_v[1]), .ext_rst_n(ext_rst_n), .nmi_n(nmi_v[1]),
      .irq_n(irq_n), .irq_en(irq_en), .sync(sync_v[1]), .i_flag(i_flag),
      .int_ack(ack_v[1]), .rst_req(rr1), .nmi_req(nr1), .irq_req(ir1),
      .vec(vv1), .irq_src(ss1)
   );

   function automatic obs_t o(input logic r, input logic n, input logic i,
                              input logic [15:0] v, input logic [N-1:0] s);
      obs_t x;
      x.r = r; x.n = n; x.i = i; x.v = v; x.s = s;
      return x;
   endfunction

   task automatic check(input int u, input obs_t a);
      obs_t  e;
      string nm;
      n_chk++;
      if ((u == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
         $display("FAIL u%0d unexpected_sample: got %h, want no sample", u, a);
      end else begin
         if (u == 0) begin e = q0.pop_front(); nm = n0.pop_front(); end
         else        begin e = q1.pop_front(); nm = n1.pop_front(); end
         if (a === e) n_pass++;
         else $display("FAIL u%0d %s: got rst=%b nmi=%b irq=%b vec=%h src=%b, want rst=%b nmi=%b irq=%b vec=%h src=%b",
                       u, nm, a.r, a.n, a.i, a.v, a.s, e.r, e.n, e.i, e.v, e.s);
      end
   endtask

   // Monitor: the DUT presents a request to the CPU on every ack and every probe cycle.
   always @(negedge clk) begin
      if (probe_v[0] || ack_v[0]) check(0, {rr0, nr0, ir0, vv0, ss0});
      if (probe_v[1] || ack_v[1]) check(1, {rr1, nr1, ir1, vv1, ss1});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int u, input string nm, input obs_t e);
      if (u == 0) begin q0.push_back(e); n0.push_back(nm); end
      else        begin q1.push_back(e); n1.push_back(nm); end
   endtask

   task automatic probe_chk(input int u, input string nm, input obs_t e);
      push(u, nm, e);
      probe_v[u] = 1'b1;
      tick();
      probe_v[u] = 1'b0;
   endtask

   task automatic ack_chk(input int u, input string nm, input obs_t e);
      push(u, nm, e);
      ack_v[u] = 1'b1;
      tick();
      ack_v[u] = 1'b0;
   endtask

   task automatic sync_p(input int u);
      sync_v[u] = 1'b1;
      tick();
      sync_v[u] = 1'b0;
   endtask

   initial begin
      ext_rst_n = 1'b1;
      irq_n     = '1;
      irq_en    = '0;
      i_flag    = 1'b1;
      for (int u = 0; u < 2; u++) begin
         rst_v[u] = 1'b1; sync_v[u] = 1'b0; ack_v[u] = 1'b0;
         probe_v[u] = 1'b0; nmi_v[u] = 1'b1;
      end

      // Reset sequence
      tick(); tick();
      probe_chk(0, "reset_state", o(1, 0, 0, 16'hFFFC, 4'b0000));
      rst_v[0] = 1'b0;
      probe_chk(0, "rst_hold", o(1, 0, 0, 16'hFFFC, 4'b0000));
      sync_p(0);
      probe_chk(0, "rst_committed", o(1, 0, 0, 16'hFFFC, 4'b0000));
      ack_chk(0, "rst_ack", o(1, 0, 0, 16'hFFFC, 4'b0000));
      probe_chk(0, "rst_released", o(0, 0, 0, 16'hFFFE, 4'b0000));

      // NMI held low: exactly one request
      nmi_v[0] = 1'b0;
      repeat (3) tick();
      probe_chk(0, "nmi_pending_uncommitted", o(0, 0, 0, 16'hFFFE, 4'b0000));
      sync_p(0);
      probe_chk(0, "nmi_committed", o(0, 1, 0, 16'hFFFA, 4'b0000));
      ack_chk(0, "nmi_ack", o(0, 1, 0, 16'hFFFA, 4'b0000));
      for (int k = 0; k < 10; k++) begin
         sync_p(0);
         tick(); tick();
         probe_chk(0, "nmi_no_repeat", o(0, 0, 0, 16'hFFFE, 4'b0000));
      end
      nmi_v[0] = 1'b1;
      repeat (4) tick();

      // IRQ merge, enable and mask
      irq_n = 4'b1101; irq_en = 4'b0010; i_flag = 1'b0;
      repeat (3) tick();
      probe_chk(0, "irq_src_status", o(0, 0, 0, 16'hFFFE, 4'b0010));
      sync_p(0);
      probe_chk(0, "irq_committed", o(0, 0, 1, 16'hFFFE, 4'b0010));
      ack_chk(0, "irq_ack", o(0, 0, 1, 16'hFFFE, 4'b0010));
      i_flag = 1'b1;
      sync_p(0);
      probe_chk(0, "irq_masked", o(0, 0, 0, 16'hFFFE, 4'b0010));

      // NMI hijacks a committed IRQ
      i_flag = 1'b0;
      sync_p(0);
      probe_chk(0, "irq_before_hijack", o(0, 0, 1, 16'hFFFE, 4'b0010));
      nmi_v[0] = 1'b0;
      repeat (3) tick();
      probe_chk(0, "hijack", o(0, 1, 0, 16'hFFFA, 4'b0010));
      ack_chk(0, "hijack_ack", o(0, 1, 0, 16'hFFFA, 4'b0010));
      probe_chk(0, "hijack_cleared", o(0, 0, 0, 16'hFFFE, 4'b0010));
      sync_p(0);
      probe_chk(0, "irq_recommitted", o(0, 0, 1, 16'hFFFE, 4'b0010));
      ack_chk(0, "irq_recommit_ack", o(0, 0, 1, 16'hFFFE, 4'b0010));
      nmi_v[0] = 1'b1;
      repeat (3) tick();

      // NMI and IRQ together: NMI first
      nmi_v[0] = 1'b0;
      repeat (3) tick();
      sync_p(0);
      probe_chk(0, "nmi_over_irq", o(0, 1, 0, 16'hFFFA, 4'b0010));
      ack_chk(0, "nmi_over_irq_ack", o(0, 1, 0, 16'hFFFA, 4'b0010));
      sync_p(0);
      probe_chk(0, "irq_after_nmi", o(0, 0, 1, 16'hFFFE, 4'b0010));
      nmi_v[0] = 1'b1;

      // One-cycle reset pin pulse preempts the committed IRQ
      ext_rst_n = 1'b0;
      tick();
      ext_rst_n = 1'b1;
      probe_chk(0, "irq_before_rst_pin", o(0, 0, 1, 16'hFFFE, 4'b0010));
      tick();
      probe_chk(0, "rst_preempt", o(1, 0, 0, 16'hFFFC, 4'b0010));
      probe_chk(0, "rst_preempt_held", o(1, 0, 0, 16'hFFFC, 4'b0010));
      ack_chk(0, "rst_pin_ack", o(1, 0, 0, 16'hFFFC, 4'b0010));
      probe_chk(0, "rst_pin_released", o(0, 0, 0, 16'hFFFE, 4'b0010));
      ack_chk(0, "ack_idle", o(0, 0, 0, 16'hFFFE, 4'b0010));
      probe_chk(0, "ack_idle_after", o(0, 0, 0, 16'hFFFE, 4'b0010));

      // System reset mid-sequence discards the selection and the pending NMI
      sync_p(0);
      probe_chk(0, "irq_before_rst", o(0, 0, 1, 16'hFFFE, 4'b0010));
      nmi_v[0] = 1'b0;
      repeat (3) tick();
      probe_chk(0, "hijack_before_rst", o(0, 1, 0, 16'hFFFA, 4'b0010));
      nmi_v[0] = 1'b1;
      rst_v[0] = 1'b1;
      tick();
      rst_v[0] = 1'b0;
      probe_chk(0, "rst_discard", o(1, 0, 0, 16'hFFFC, 4'b0000));
      sync_p(0);
      ack_chk(0, "rst_discard_ack", o(1, 0, 0, 16'hFFFC, 4'b0010));
      sync_p(0);
      probe_chk(0, "pend_discarded", o(0, 0, 1, 16'hFFFE, 4'b0010));
      irq_n = '1; irq_en = '0;

      // Level-sensitive NMI build: a request after every ack while the pin stays low
      probe_chk(1, "lvl_reset_state", o(1, 0, 0, 16'hFFFC, 4'b0000));
      rst_v[1] = 1'b0;
      sync_p(1);
      ack_chk(1, "lvl_rst_ack", o(1, 0, 0, 16'hFFFC, 4'b0000));
      nmi_v[1] = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         sync_p(1);
         probe_chk(1, "lvl_nmi_req", o(0, 1, 0, 16'hFFFA, 4'b0000));
         ack_chk(1, "lvl_nmi_ack", o(0, 1, 0, 16'hFFFA, 4'b0000));
         probe_chk(1, "lvl_idle_between", o(0, 0, 0, 16'hFFFE, 4'b0000));
      end
      nmi_v[1] = 1'b1;
      repeat (3) tick();

      n_chk++;
      if (q0.size() == 0 && q1.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drained: got %0d/%0d entries left, want 0/0", q0.size(), q1.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
